// File: rtl/fp_op_sequencer.sv
// fp_op_sequencer: runs one FP command at a time through the register memory
// and an external FP ALU (read operands, issue, wait for result, write back).
module fp_op_sequencer #(
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned OP_W    = 3,
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [OP_W-1:0]   cmd_op,
   input  logic [ADDR_W-1:0] cmd_src1,
   input  logic [ADDR_W-1:0] cmd_src2,
   input  logic [ADDR_W-1:0] cmd_dst,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr1,
   output logic [ADDR_W-1:0] mem_rd_addr2,
   input  logic [DATA_W-1:0] mem_rd_data1,
   input  logic [DATA_W-1:0] mem_rd_data2,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   output logic              alu_valid,
   input  logic              alu_ready,
   output logic [OP_W-1:0]   alu_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic              alu_res_valid,
   input  logic [DATA_W-1:0] alu_res,
   output logic              busy,
   output logic              done,
   output logic              timeout_err,
   input  logic              err_clr,
   output logic [CNT_W-1:0]  cmd_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_CAPT,
      S_ISSUE,
      S_WAIT,
      S_WRITE
   } state_t;

   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state_q;
   state_t           state_nx;
   logic [OP_W-1:0]  op_q;
   logic [CNT_W-1:0] timer_q;
   logic             cmd_hs;
   logic             timeout_hit;

   assign cmd_hs      = (state_q == S_IDLE) && cmd_valid;
   assign timeout_hit = (state_q == S_WAIT) && !alu_res_valid && (timer_q == TMO_LAST);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_nx;
   end

   // Next-state decode
   always_comb begin
      state_nx = state_q;
      case (state_q)
         S_IDLE:  if (cmd_valid) state_nx = S_READ;
         S_READ:  state_nx = S_CAPT;
         S_CAPT:  state_nx = S_ISSUE;
         S_ISSUE: if (alu_ready) state_nx = S_WAIT;
         S_WAIT: begin
            if (alu_res_valid)     state_nx = S_WRITE;
            else if (timeout_hit)  state_nx = S_IDLE;
         end
         S_WRITE: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Strobes are registered from the next state so they line up with the state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         mem_rd_en <= 1'b0;
         alu_valid <= 1'b0;
         mem_wr_en <= 1'b0;
         done      <= 1'b0;
      end else begin
         cmd_ready <= (state_nx == S_IDLE);
         busy      <= (state_nx != S_IDLE);
         mem_rd_en <= (state_nx == S_READ);
         alu_valid <= (state_nx == S_ISSUE);
         mem_wr_en <= (state_nx == S_WRITE);
         done      <= (state_nx == S_WRITE);
      end
   end

   // Command, operand and result latches
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q         <= '0;
         mem_rd_addr1 <= '0;
         mem_rd_addr2 <= '0;
         mem_wr_addr  <= '0;
         alu_op       <= '0;
         alu_a        <= '0;
         alu_b        <= '0;
         mem_wr_data  <= '0;
      end else begin
         if (cmd_hs) begin
            op_q         <= cmd_op;
            mem_rd_addr1 <= cmd_src1;
            mem_rd_addr2 <= cmd_src2;
            mem_wr_addr  <= cmd_dst;
         end
         if (state_q == S_CAPT) begin
            alu_op <= op_q;
            alu_a  <= mem_rd_data1;
            alu_b  <= mem_rd_data2;
         end
         if ((state_q == S_WAIT) && alu_res_valid) mem_wr_data <= alu_res;
      end
   end

   // WAIT timer: runs only while waiting, zero everywhere else
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                   timer_q <= '0;
      else if (state_q == S_WAIT) timer_q <= timer_q + 1'b1;
      else                        timer_q <= '0;
   end

   // Sticky timeout flag; a same-cycle clear beats the set
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)             timeout_err <= 1'b0;
      else if (err_clr)     timeout_err <= 1'b0;
      else if (timeout_hit) timeout_err <= 1'b1;
   end

   // Completed write-back counter, bumps together with the done pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                        cmd_count <= '0;
      else if (state_nx == S_WRITE)    cmd_count <= cmd_count + 1'b1;
   end

endmodule

// File: tb/tb_fp_op_sequencer.sv
// Testbench for fp_op_sequencer: directed + randomized commands against a
// register-file / counter / error-flag reference model.
module tb_fp_op_sequencer;

   localparam int AW  = 5;
   localparam int DW  = 32;
   localparam int OW  = 3;
   localparam int TMO = 8;
   localparam int CW  = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid, cmd_ready;
   logic [OW-1:0] cmd_op;
   logic [AW-1:0] cmd_src1, cmd_src2, cmd_dst;
   logic          mem_rd_en;
   logic [AW-1:0] mem_rd_addr1, mem_rd_addr2;
   logic [DW-1:0] mem_rd_data1, mem_rd_data2;
   logic          mem_wr_en;
   logic [AW-1:0] mem_wr_addr;
   logic [DW-1:0] mem_wr_data;
   logic          alu_valid, alu_ready;
   logic [OW-1:0] alu_op;
   logic [DW-1:0] alu_a, alu_b;
   logic          alu_res_valid;
   logic [DW-1:0] alu_res;
   logic          busy, done, timeout_err, err_clr;
   logic [CW-1:0] cmd_count;

   always #5 clk = ~clk;

   fp_op_sequencer #(
      .ADDR_W(AW), .DATA_W(DW), .OP_W(OW), .TIMEOUT(TMO), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_dst(cmd_dst),
      .mem_rd_en(mem_rd_en), .mem_rd_addr1(mem_rd_addr1), .mem_rd_addr2(mem_rd_addr2),
      .mem_rd_data1(mem_rd_data1), .mem_rd_data2(mem_rd_data2),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_op(alu_op),
      .alu_a(alu_a), .alu_b(alu_b),
      .alu_res_valid(alu_res_valid), .alu_res(alu_res),
      .busy(busy), .done(done), .timeout_err(timeout_err), .err_clr(err_clr),
      .cmd_count(cmd_count)
   );

   // Environment: 32x32 register memory with one-cycle read latency
   logic [DW-1:0] env_mem [32];
   logic          load_en = 1'b0;
   logic [AW-1:0] load_addr = '0;
   logic [DW-1:0] load_data = '0;
   int            wr_cnt = 0, iss_cnt = 0, cyc = 0, last_acc = 0, acc_gap = 0;

   always @(posedge clk) begin
      if (load_en)        env_mem[load_addr] <= load_data;
      else if (mem_wr_en) env_mem[mem_wr_addr] <= mem_wr_data;
      if (mem_rd_en) begin
         mem_rd_data1 <= env_mem[mem_rd_addr1];
         mem_rd_data2 <= env_mem[mem_rd_addr2];
      end
   end

   // Event counters observed at the clock edge
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_wr_en) wr_cnt <= wr_cnt + 1;
      if (alu_valid && alu_ready) iss_cnt <= iss_cnt + 1;
      if (cmd_valid && cmd_ready) begin
         acc_gap  <= cyc - last_acc;
         last_acc <= cyc;
      end
   end

   // Reference model state
   logic [DW-1:0] ref_mem [32];
   int            ref_count = 0;
   logic          ref_err = 1'b0;
   int            exp_gap = 0;

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      return (a ^ {b[15:0], b[31:16]}) + 32'(op);
   endfunction

   // One full command; starts and ends at a negedge with the DUT idle.
   // res_dly >= TMO means the ALU never answers.
   task automatic run_cmd(input logic [2:0] op, input logic [4:0] s1, input logic [4:0] s2,
                          input logic [4:0] d, input int rdy_dly, input int res_dly,
                          input logic [31:0] res, input bit clr_at_to);
      logic [31:0] ea, eb;
      int wr0, is0;
      ea  = ref_mem[s1];
      eb  = ref_mem[s2];
      wr0 = wr_cnt;
      is0 = iss_cnt;
      check("idle_ready", 32'(cmd_ready), 1);
      check("idle_busy", 32'(busy), 0);
      cmd_valid = 1'b1; cmd_op = op; cmd_src1 = s1; cmd_src2 = s2; cmd_dst = d;
      @(negedge clk);                                   // READ
      cmd_op = 3'($urandom); cmd_src1 = 5'($urandom);
      cmd_src2 = 5'($urandom); cmd_dst = 5'($urandom);  // held valid, must be ignored
      check("rd_en", 32'(mem_rd_en), 1);
      check("rd_addr1", 32'(mem_rd_addr1), 32'(s1));
      check("rd_addr2", 32'(mem_rd_addr2), 32'(s2));
      check("busy_ready", 32'({busy, cmd_ready}), 32'b10);
      if (exp_gap != 0) check("accept_gap", 32'(acc_gap), 32'(exp_gap));
      @(negedge clk);                                   // CAPT
      check("rd_en_once", 32'(mem_rd_en), 0);
      alu_res_valid = 1'b1; alu_res = $urandom;         // stray result outside WAIT
      @(negedge clk);                                   // ISSUE
      alu_res_valid = 1'b0;
      check("alu_valid", 32'(alu_valid), 1);
      check("alu_op", 32'(alu_op), 32'(op));
      check("alu_a", alu_a, ea);
      check("alu_b", alu_b, eb);
      for (int k = 0; k < rdy_dly; k++) begin
         alu_ready = 1'b0;
         @(negedge clk);
         check("bp_valid", 32'(alu_valid), 1);
         check("bp_op", 32'(alu_op), 32'(op));
         check("bp_a", alu_a, ea);
         check("bp_b", alu_b, eb);
      end
      alu_ready = 1'b1;
      cmd_valid = 1'b0;
      @(negedge clk);                                   // first WAIT cycle
      alu_ready = 1'b0;
      check("valid_drop", 32'(alu_valid), 0);
      check("issue_once", 32'(iss_cnt - is0), 1);
      if (res_dly < TMO) begin
         repeat (res_dly) @(negedge clk);
         alu_res_valid = 1'b1; alu_res = res;
         @(negedge clk);                                // WRITE
         alu_res_valid = 1'b0; alu_res = $urandom;
         ref_mem[d] = res;
         ref_count  = (ref_count + 1) % (1 << CW);
         check("wr_en", 32'(mem_wr_en), 1);
         check("wr_addr", 32'(mem_wr_addr), 32'(d));
         check("wr_data", mem_wr_data, res);
         check("done", 32'(done), 1);
         check("count", 32'(cmd_count), 32'(ref_count));
         @(negedge clk);                                // IDLE
         check("done_pulse", 32'({done, mem_wr_en}), 0);
         check("back_idle", 32'(cmd_ready), 1);
         check("write_once", 32'(wr_cnt - wr0), 1);
         check("err_sticky", 32'(timeout_err), 32'(ref_err));
         exp_gap = 6 + rdy_dly + res_dly;
      end else begin
         repeat (TMO - 1) @(negedge clk);               // last WAIT cycle
         check("to_last_busy", 32'(busy), 1);
         if (clr_at_to) err_clr = 1'b1;
         @(negedge clk);
         err_clr = 1'b0;
         if (!clr_at_to) ref_err = 1'b1;
         check("to_idle", 32'({busy, cmd_ready}), 32'b01);
         check("to_err", 32'(timeout_err), 32'(ref_err));
         check("to_count", 32'(cmd_count), 32'(ref_count));
         check("to_nowrite", 32'(wr_cnt - wr0), 0);
         exp_gap = 4 + rdy_dly + TMO;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0] s1, s2, d;
      int rd, sd;
      rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_src1 = '0; cmd_src2 = '0; cmd_dst = '0;
      alu_ready = 1'b0; alu_res_valid = 1'b0; alu_res = '0; err_clr = 1'b0;

      // Load memory while held in reset
      load_en = 1'b1;
      for (int unsigned i = 0; i < 32; i++) begin
         load_addr = 5'(i);
         load_data = (i == 1) ? 32'h3F800000 : (i == 2) ? 32'h40000000 : $urandom;
         ref_mem[i] = load_data;
         @(negedge clk);
      end
      load_en = 1'b0;
      check("rst_ready", 32'(cmd_ready), 1);
      check("rst_strobes", 32'({busy, done, mem_rd_en, mem_wr_en, alu_valid}), 0);
      check("rst_err", 32'(timeout_err), 0);
      check("rst_count", 32'(cmd_count), 0);
      check("rst_data", alu_a | alu_b | mem_wr_data, 0);
      rst = 1'b1;
      @(negedge clk);

      // Basic op, then back-to-back read-after-write of dst 3
      run_cmd(3'd0, 5'd1, 5'd2, 5'd3, 0, 0, 32'h40400000, 1'b0);
      run_cmd(3'd1, 5'd3, 5'd2, 5'd4, 0, 0, 32'h40A00000, 1'b0);
      check("raw_a", ref_mem[3], 32'h40400000);

      // ALU backpressure, src1==src2==dst, late result on the final WAIT cycle
      run_cmd(3'd2, 5'd4, 5'd1, 5'd5, 4, 0, alu_fn(3'd2, ref_mem[4], ref_mem[1]), 1'b0);
      run_cmd(3'd3, 5'd7, 5'd7, 5'd7, 1, 2, alu_fn(3'd3, ref_mem[7], ref_mem[7]), 1'b0);
      run_cmd(3'd4, 5'd6, 5'd8, 5'd9, 0, TMO - 1, 32'hDEADBEEF, 1'b0);

      // Timeout, sticky error across a good command, then clear
      run_cmd(3'd5, 5'd1, 5'd2, 5'd10, 0, TMO, 32'h0, 1'b0);
      run_cmd(3'd6, 5'd10, 5'd3, 5'd11, 0, 0, 32'h12345678, 1'b0);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      ref_err = 1'b0;
      exp_gap = 0;
      check("err_clr", 32'(timeout_err), 0);
      // Clear in the very cycle the timeout fires keeps the error clear
      run_cmd(3'd7, 5'd2, 5'd2, 5'd12, 2, TMO, 32'h0, 1'b1);

      // Reset while waiting for the ALU
      cmd_valid = 1'b1; cmd_op = 3'd1; cmd_src1 = 5'd1; cmd_src2 = 5'd2; cmd_dst = 5'd13;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      alu_ready = 1'b1;
      @(negedge clk);
      alu_ready = 1'b0;
      @(negedge clk);
      check("pre_rst_busy", 32'(busy), 1);
      #2 rst = 1'b0;
      #1;
      ref_count = 0;
      ref_err   = 1'b0;
      check("mid_rst_ready", 32'(cmd_ready), 1);
      check("mid_rst_strobes", 32'({busy, done, mem_rd_en, mem_wr_en, alu_valid, timeout_err}), 0);
      check("mid_rst_regs", 32'(alu_op) | alu_a | alu_b | mem_wr_data | 32'(mem_wr_addr) | 32'(mem_rd_addr1), 0);
      check("mid_rst_count", 32'(cmd_count), 0);
      rd = wr_cnt;
      @(negedge clk);
      rst = 1'b1;
      alu_res_valid = 1'b1; alu_res = 32'hBADBAD00;
      @(negedge clk);
      alu_res_valid = 1'b0;
      @(negedge clk);
      check("rst_nowrite", 32'(wr_cnt - rd), 0);
      check("rst_idle", 32'({busy, cmd_ready}), 32'b01);
      exp_gap = 0;

      // Randomized commands; the 4-bit counter wraps along the way
      for (int unsigned i = 0; i < 24; i++) begin
         s1 = 5'($urandom); s2 = 5'($urandom); d = 5'($urandom);
         if (($urandom % 4) == 0) s2 = s1;
         if (($urandom % 4) == 0) d = s1;
         rd = int'($urandom_range(0, 3));
         sd = (($urandom % 8) == 0) ? TMO : int'($urandom_range(0, TMO - 1));
         run_cmd(3'($urandom), s1, s2, d, rd, sd,
                 alu_fn(3'(i), ref_mem[s1], ref_mem[s2]) ^ 32'(i), 1'b0);
      end

      // Final memory image against the model
      @(negedge clk);
      for (int unsigned i = 0; i < 32; i++) check("mem_final", env_mem[i], ref_mem[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
